aska_spi: RTL and testbench

- Write-only SPI slave configuration block for an ASKA chip.
- An external master sends 40-bit frames: an 8-bit address byte followed by a 32-bit data word.
- Each complete frame addressed to this chip's 2-bit IC address updates one of four 32-bit configuration registers.
- The registers drive the chip's analog/digital configuration and are held in the slow system clock domain.

---
 rtl/aska_spi.sv | 158 +++++++++++++++
 tb/tb_aska_spi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aska_spi.sv
// rtl/aska_spi.sv - write-only SPI slave holding four 32-bit ASKA configuration registers
// Optional status outputs (frame_err, wr_cnt) are built when ASKA_SPI_STATUS_EN is defined.
`timescale 1ns/1ps

module aska_spi #(
  parameter int NUM_BITS = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SPI_CS,
  input  logic        SPI_Clk,
  input  logic        SPI_MOSI,
  input  logic [1:0]  IC_addr,
  output logic [31:0] conf0,
  output logic [31:0] conf1,
  output logic [31:0] ele1,
  output logic [31:0] ele2
`ifdef ASKA_SPI_STATUS_EN
  ,
  output logic        frame_err,
  output logic [7:0]  wr_cnt
`endif
);

  localparam logic [5:0] FULL_CNT = 6'(NUM_BITS);
  localparam logic [5:0] LAST_CNT = 6'(NUM_BITS - 1);

  logic [5:0]          bit_cnt_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] shift_d;
  logic [NUM_BITS-1:0] hold_q;
  logic                done_tog_q;
  logic [2:0]          done_sync_q;
  logic [3:0][31:0]    regs_q;
  logic [3:0][31:0]    regs_d;
  logic                commit;
  logic                ic_match;
  logic                wr_en;
  logic [1:0]          frame_ic;
  logic [5:0]          frame_idx;
  logic [31:0]         frame_data;

  assign shift_d = {shift_q[NUM_BITS-2:0], SPI_MOSI};

  // Bit counter: deasserting CS drops any partial frame; saturates at a full frame.
  always_ff @(posedge SPI_Clk or posedge resetn or posedge SPI_CS) begin
    if (resetn || SPI_CS) begin
      bit_cnt_q <= '0;
    end else if (bit_cnt_q != FULL_CNT) begin
      bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge SPI_Clk or posedge resetn) begin
    if (resetn) begin
      shift_q    <= '0;
      hold_q     <= '0;
      done_tog_q <= 1'b0;
    end else if (!SPI_CS && bit_cnt_q != FULL_CNT) begin
      shift_q <= shift_d;
      if (bit_cnt_q == LAST_CNT) begin
        hold_q     <= shift_d;
        done_tog_q <= ~done_tog_q;
      end
    end
  end

  // Two synchronizer flops plus one reference flop for toggle edge detection.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      done_sync_q <= '0;
    end else begin
      done_sync_q <= {done_sync_q[1:0], done_tog_q};
    end
  end

  assign commit     = done_sync_q[2] ^ done_sync_q[1];
  assign frame_ic   = hold_q[NUM_BITS-1 -: 2];
  assign frame_idx  = hold_q[NUM_BITS-3 -: 6];
  assign frame_data = hold_q[31:0];
  assign ic_match   = (frame_ic == IC_addr);
  assign wr_en      = commit && ic_match && (frame_idx[5:2] == 4'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[frame_idx[1:0]] = frame_data;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign conf0 = regs_q[0];
  assign conf1 = regs_q[1];
  assign ele1  = regs_q[2];
  assign ele2  = regs_q[3];

`ifdef ASKA_SPI_STATUS_EN
  logic       err_tog_q;
  logic [2:0] err_sync_q;
  logic       err_evt;
  logic       frame_err_q;
  logic       frame_err_d;
  logic [7:0] wr_cnt_q;
  logic [7:0] wr_cnt_d;

  // Sampled on the CS rising edge, before the counter clear takes effect.
  always_ff @(posedge SPI_CS or posedge resetn) begin
    if (resetn) begin
      err_tog_q <= 1'b0;
    end else if (bit_cnt_q != 6'd0 && bit_cnt_q != FULL_CNT) begin
      err_tog_q <= ~err_tog_q;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      err_sync_q <= '0;
    end else begin
      err_sync_q <= {err_sync_q[1:0], err_tog_q};
    end
  end

  assign err_evt = err_sync_q[2] ^ err_sync_q[1];

  always_comb begin
    frame_err_d = frame_err_q;
    wr_cnt_d    = wr_cnt_q;
    if (wr_en) begin
      frame_err_d = 1'b0;
      wr_cnt_d    = wr_cnt_q + 8'd1;
    end
    if (err_evt || (commit && !ic_match)) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      frame_err_q <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      frame_err_q <= frame_err_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign frame_err = frame_err_q;
  assign wr_cnt    = wr_cnt_q;
`endif

endmodule

// File: tb/tb_aska_spi.sv
// tb/tb_aska_spi.sv - scoreboard bench for aska_spi with directed frames
`timescale 1ns/1ps

module tb_aska_spi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        SPI_CS;
  logic        SPI_Clk;
  logic        SPI_MOSI;
  logic [1:0]  IC_addr;
  logic [31:0] conf0, conf1, ele1, ele2;
`ifdef ASKA_SPI_STATUS_EN
  logic        frame_err;
  logic [7:0]  wr_cnt;
`endif

  aska_spi dut (
    .clk      (clk),
    .resetn   (resetn),
    .SPI_CS   (SPI_CS),
    .SPI_Clk  (SPI_Clk),
    .SPI_MOSI (SPI_MOSI),
    .IC_addr  (IC_addr),
    .conf0    (conf0),
    .conf1    (conf1),
    .ele1     (ele1),
    .ele2     (ele2)
`ifdef ASKA_SPI_STATUS_EN
    ,
    .frame_err(frame_err),
    .wr_cnt   (wr_cnt)
`endif
  );

  always #25 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    int          due;
    logic [31:0] c0, c1, e1, e2;
    logic        ferr;
    logic [7:0]  wcnt;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] x_c0, x_c1, x_e1, x_e2;
  logic        x_ferr;
  logic [7:0]  x_wcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  task automatic push_exp(input string nm, input int due);
    exp_t e;
    e.nm = nm; e.due = due;
    e.c0 = x_c0; e.c1 = x_c1; e.e1 = x_e1; e.e2 = x_e2;
    e.ferr = x_ferr; e.wcnt = x_wcnt;
    exp_q.push_back(e);
  endtask

  task automatic set_exp(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] e1,
                         input logic [31:0] e2, input logic ferr, input logic [7:0] wcnt);
    x_c0 = c0; x_c1 = c1; x_e1 = e1; x_e2 = e2; x_ferr = ferr; x_wcnt = wcnt;
  endtask

  // Monitor: compares DUT outputs against each expectation once it falls due.
  exp_t m;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      m = exp_q.pop_front();
      chk({m.nm, ".conf0"}, conf0, m.c0);
      chk({m.nm, ".conf1"}, conf1, m.c1);
      chk({m.nm, ".ele1"},  ele1,  m.e1);
      chk({m.nm, ".ele2"},  ele2,  m.e2);
`ifdef ASKA_SPI_STATUS_EN
      chk({m.nm, ".frame_err"}, {31'd0, frame_err}, {31'd0, m.ferr});
      chk({m.nm, ".wr_cnt"},    {24'd0, wr_cnt},    {24'd0, m.wcnt});
`endif
    end
  end

  // SPI edges land on even ns offsets from a clk negedge, never on a clk posedge.
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input int nbits,
                            input bit raise_cs, output int c40);
    logic [39:0] w;
    w = {addr, data};
    c40 = -1;
    @(negedge clk);
    #4 SPI_CS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = (i < 40) ? w[39-i] : 1'b1;
      #2 SPI_Clk = 1'b1;
      if (i == 39) c40 = cyc;
      #2 SPI_Clk = 1'b0;
    end
    #2;
    if (raise_cs) SPI_CS = 1'b1;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] addr, input logic [31:0] data,
                           input int nbits);
    int c40;
    send_frame(addr, data, nbits, 1'b1, c40);
    if (nbits >= 40) push_exp(nm, c40 + 3);
    else             push_exp(nm, cyc + 4);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int c40;
    resetn = 1'b1; SPI_CS = 1'b1; SPI_Clk = 1'b0; SPI_MOSI = 1'b0; IC_addr = 2'b11;
    set_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 8'd0);
    push_exp("reset", 2);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    repeat (2) @(posedge clk);

    set_exp(32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b0, 8'd1);
    run_frame("wr_conf0", 8'hC0, 32'hAABBCCDD, 40);

    set_exp(32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b1, 8'd1);
    run_frame("short_frame", 8'h03, 32'h55446600, 32);

    set_exp(32'hAABBCCDD, 32'h3377EEFF, 32'h0, 32'h0, 1'b0, 8'd2);
    run_frame("wr_conf1", 8'hC1, 32'h3377EEFF, 40);
    set_exp(32'hAABBCCDD, 32'h3377EEFF, 32'hBEBECACA, 32'h0, 1'b0, 8'd3);
    run_frame("wr_ele1", 8'hC2, 32'hBEBECACA, 40);
    set_exp(32'hAABBCCDD, 32'h3377EEFF, 32'hBEBECACA, 32'hCAFEBABA, 1'b0, 8'd4);
    run_frame("wr_ele2", 8'hC3, 32'hCAFEBABA, 40);

    run_frame("bad_index", 8'hC4, 32'hDEADDEAD, 40);

    set_exp(32'hAABBCCDD, 32'h3377EEFF, 32'hBEBECACA, 32'hCAFEBABA, 1'b1, 8'd4);
    run_frame("ic_mismatch", 8'h80, 32'h12345678, 40);

    IC_addr = 2'b10;
    set_exp(32'h12345678, 32'h3377EEFF, 32'hBEBECACA, 32'hCAFEBABA, 1'b0, 8'd5);
    run_frame("ic_match10", 8'h80, 32'h12345678, 40);
    IC_addr = 2'b11;

    set_exp(32'h12345678, 32'h3377EEFF, 32'h0BADF00D, 32'hCAFEBABA, 1'b0, 8'd6);
    run_frame("overlong", 8'hC2, 32'h0BADF00D, 48);

    send_frame(8'hC1, 32'h11111111, 20, 1'b0, c40);
    resetn = 1'b1;
    set_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 8'd0);
    push_exp("mid_reset", cyc + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #4 resetn = 1'b0;
    #4 SPI_CS = 1'b1;
    push_exp("post_reset_idle", cyc + 4);
    repeat (6) @(posedge clk);

    set_exp(32'h0, 32'h11111111, 32'h0, 32'h0, 1'b0, 8'd1);
    run_frame("after_reset", 8'hC1, 32'h11111111, 40);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
